fb_write_arbiter: RTL
=====================

# fb_write_arbiter

Shares the single write port (port A) of the 160x120 1-bit frame buffer between two requesters. The first is the processor-bus pixel write path. The second is a hardware clear/fill engine that paints every pixel with one value. The block sits between the bus-side VGA register logic and the frame buffer. It sequences the fill engine and grants the port round-robin when both requesters are active.

## Interface
- X_PIXELS, 160, horizontal resolution; X coordinate range 0..X_PIXELS-1
- Y_PIXELS, 120, vertical resolution; Y coordinate range 0..Y_PIXELS-1
- CLK  in  1  system clock; all logic on rising edge
- RESET  in  1  synchronous, active-low reset
- WR_VALID  in  1  bus-side pixel write request
- WR_READY  out  1  bus-side write accepted this cycle when high together with WR_VALID
- WR_X  in  8  pixel column
- WR_Y  in  7  pixel row
- WR_PIXEL  in  1  pixel value
- CLR_START  in  1  single-cycle pulse; starts a full-frame fill
- CLR_PIXEL  in  1  fill value; sampled on the accepted CLR_START cycle
- FB_ADDR  out  15  frame buffer address {Y[6:0], X[7:0]}
- FB_DATA  out  1  frame buffer write data
- FB_WE  out  1  frame buffer write enable
- CLR_BUSY  out  1  high while a fill is in progress
- CLR_DONE  out  1  one-cycle pulse when a fill completes
- WR_DROP  out  1  one-cycle pulse when an accepted bus write is out of range

## Operation
- FSM states:
  - IDLE: WR_READY=1. A bus handshake issues a write. CLR_START moves the FSM to FILL and latches CLR_PIXEL; the fill counters reset to (0,0).
  - FILL: one port slot per cycle. Bus requests compete with the fill engine for that slot (arbitration below).
  - DONE: asserts CLR_DONE for one cycle, WR_READY=1, then returns to IDLE.
- Arbitration in FILL uses a 1-bit last-grant register:
  - WR_VALID=0: the fill engine takes the slot.
  - WR_VALID=1: the requester not granted last time wins. Concurrent traffic therefore alternates bus, fill, bus, fill.
  - WR_READY is combinational: high in IDLE and DONE. In FILL it is high when the last-grant register points at the fill engine.
- Fill counters:
  - X increments 0..X_PIXELS-1. On wrap to 0, Y increments.
  - Issuing (X_PIXELS-1, Y_PIXELS-1) moves the FSM to DONE.
  - Counters advance only on cycles the fill engine is granted.
- Bus range check: a handshake with WR_X >= X_PIXELS or WR_Y >= Y_PIXELS completes normally. It produces no FB_WE and pulses WR_DROP.
- CLR_START while in FILL or DONE is ignored. CLR_PIXEL changes during FILL have no effect.
- Simultaneous CLR_START and a bus handshake in IDLE: the bus write is issued that cycle and FILL starts next cycle.
- Because arbitration alternates, a bus write during FILL may land before or after the fill pass over the same pixel. Software issues its writes after CLR_DONE if ordering matters.

## Timing
- FB_ADDR, FB_DATA, FB_WE, CLR_DONE and WR_DROP are registered and appear the cycle after the grant or handshake.
- CLR_BUSY is registered:
  - rises the cycle after accepted CLR_START;
  - falls in the same cycle CLR_DONE is high.
- Fill length with no bus traffic: CLR_START at cycle 0 gives FB_WE from cycle 2 to cycle 19201 inclusive (19200 writes) and CLR_DONE at cycle 19202.
- Under continuous WR_VALID the fill takes 38400 FILL cycles.
- Reset values: FB_ADDR=0, FB_DATA=0, FB_WE=0, CLR_BUSY=0, CLR_DONE=0, WR_DROP=0, state IDLE, last-grant register pointing at the fill engine. WR_READY=1 during and after reset.
- Reset asserted mid-fill aborts the fill the next edge. No CLR_DONE is issued and no further FB_WE occurs.

## Test plan
- Reset, then a single bus write X=5, Y=3, PIXEL=1 -> WR_READY=1 and, one cycle later, FB_WE=1 with FB_ADDR=0x0305 and FB_DATA=1.
- CLR_START with CLR_PIXEL=1 and no bus traffic -> exactly 19200 FB_WE cycles with addresses 0x0000..0x009F per row up to 0x779F, FB_DATA=1. Then one CLR_DONE pulse and CLR_BUSY low.
- Fill with WR_VALID held high throughout -> grants alternate every cycle, WR_READY toggles, fill completes after 38400 FILL cycles, and every bus write appears on FB_ADDR.
- Bus write X=160, Y=10 -> handshake completes, WR_DROP pulses, and there is no FB_WE. X=159, Y=119 -> FB_ADDR=0x779F.
- CLR_START with a same-cycle bus write in IDLE -> the bus write is issued first and the fill's first write (addr 0) follows one cycle later. A second CLR_START mid-fill is ignored (count stays 19200).
- RESET low at fill pixel 1000 -> no further FB_WE, no CLR_DONE, and all outputs at reset values the following cycle.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// Write-port arbiter for the 160x120 1-bit frame buffer: bus pixel writes and a full-frame fill engine.
module fb_write_arbiter #(
    parameter int unsigned X_PIXELS = 160,
    parameter int unsigned Y_PIXELS = 120
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        WR_VALID,
    output logic        WR_READY,
    input  logic [7:0]  WR_X,
    input  logic [6:0]  WR_Y,
    input  logic        WR_PIXEL,
    input  logic        CLR_START,
    input  logic        CLR_PIXEL,
    output logic [14:0] FB_ADDR,
    output logic        FB_DATA,
    output logic        FB_WE,
    output logic        CLR_BUSY,
    output logic        CLR_DONE,
    output logic        WR_DROP
);

    localparam int unsigned XW = 8;
    localparam int unsigned YW = 7;
    localparam int unsigned AW = XW + YW;

    localparam logic [XW-1:0] X_LIMIT = XW'(X_PIXELS);
    localparam logic [YW-1:0] Y_LIMIT = YW'(Y_PIXELS);
    localparam logic [XW-1:0] X_LAST  = XW'(X_PIXELS - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(Y_PIXELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Which requester owned the most recent FILL slot.
    typedef enum logic {
        GRANT_FILL = 1'b0,
        GRANT_BUS  = 1'b1
    } grant_e;

    state_e          state_q, state_d;
    grant_e          last_grant_q, last_grant_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic            clr_pixel_q, clr_pixel_d;
    logic [AW-1:0]   fb_addr_q, fb_addr_d;
    logic            fb_data_q, fb_data_d;
    logic            fb_we_q, fb_we_d;
    logic            clr_busy_q, clr_busy_d;
    logic            clr_done_q, clr_done_d;
    logic            wr_drop_q, wr_drop_d;

    logic            bus_grant;
    logic            fill_grant;
    logic            wr_ready_c;
    logic            bus_in_range;

    // Next-state, arbitration, fill counters and registered port outputs.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        x_d          = x_q;
        y_d          = y_q;
        clr_pixel_d  = clr_pixel_q;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        fb_we_d      = 1'b0;
        clr_done_d   = 1'b0;
        wr_drop_d    = 1'b0;
        bus_grant    = 1'b0;
        fill_grant   = 1'b0;
        bus_in_range = (WR_X < X_LIMIT) && (WR_Y < Y_LIMIT);

        // Ready is forced high while reset is held so the bus never stalls on a dead block.
        wr_ready_c   = !RESET || (state_q != ST_FILL) || (last_grant_q == GRANT_FILL);

        case (state_q)
            ST_IDLE: begin
                bus_grant = WR_VALID;
                if (CLR_START) begin
                    state_d     = ST_FILL;
                    clr_pixel_d = CLR_PIXEL;
                    x_d         = '0;
                    y_d         = '0;
                end
            end
            ST_FILL: begin
                if (WR_VALID && (last_grant_q == GRANT_FILL)) begin
                    bus_grant    = 1'b1;
                    last_grant_d = GRANT_BUS;
                end else begin
                    fill_grant   = 1'b1;
                    last_grant_d = GRANT_FILL;
                end
            end
            ST_DONE: begin
                bus_grant  = WR_VALID;
                clr_done_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fill_grant) begin
            fb_we_d   = 1'b1;
            fb_addr_d = {y_q, x_q};
            fb_data_d = clr_pixel_q;
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    y_d = y_q + YW'(1);
                end
            end else begin
                x_d = x_q + XW'(1);
            end
        end

        // Out-of-range bus writes still handshake but only flag a drop.
        if (bus_grant) begin
            if (bus_in_range) begin
                fb_we_d   = 1'b1;
                fb_addr_d = {WR_Y, WR_X};
                fb_data_d = WR_PIXEL;
            end else begin
                wr_drop_d = 1'b1;
            end
        end

        clr_busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_FILL;
            x_q          <= '0;
            y_q          <= '0;
            clr_pixel_q  <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= 1'b0;
            fb_we_q      <= 1'b0;
            clr_busy_q   <= 1'b0;
            clr_done_q   <= 1'b0;
            wr_drop_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            x_q          <= x_d;
            y_q          <= y_d;
            clr_pixel_q  <= clr_pixel_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            fb_we_q      <= fb_we_d;
            clr_busy_q   <= clr_busy_d;
            clr_done_q   <= clr_done_d;
            wr_drop_q    <= wr_drop_d;
        end
    end

    assign WR_READY = wr_ready_c;
    assign FB_ADDR  = fb_addr_q;
    assign FB_DATA  = fb_data_q;
    assign FB_WE    = fb_we_q;
    assign CLR_BUSY = clr_busy_q;
    assign CLR_DONE = clr_done_q;
    assign WR_DROP  = wr_drop_q;

endmodule
